// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider. It takes 33 cycles per operation and returns {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i. When it is undefined, every operation is unsigned.
module div_seq (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [5:0]            cnt;
  logic [5:0]            cnt_nxt;
  logic [2*DATA_W:0]     work;
  logic [2*DATA_W:0]     work_nxt;
  logic [2*DATA_W:0]     shifted;
  logic [DATA_W:0]       trial;
  logic [DATA_W-1:0]     divisor;
  logic [DATA_W-1:0]     dividend_mag;
  logic [DATA_W-1:0]     divisor_mag;
  logic [DATA_W-1:0]     quo_fix;
  logic [DATA_W-1:0]     rem_fix;
  logic [2*DATA_W-1:0]   result_nxt;
  logic                  ready_nxt;
  logic                  accept;
  logic                  load_ops;

  assign accept   = start_i && !annul_i;
  assign load_ops = (state == IDLE) && accept && (opdata2_i != '0);

`ifdef DIV_SIGNED_EN
  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic                     op1_neg;
  logic                     op2_neg;
  logic                     neg_q;
  logic                     neg_r;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

  assign op1_s        = opdata1_i;
  assign op2_s        = opdata2_i;
  assign op1_neg      = signed_div_i && (op1_s < 0);
  assign op2_neg      = signed_div_i && (op2_s < 0);
  assign dividend_mag = op1_neg ? negate(opdata1_i) : opdata1_i;
  assign divisor_mag  = op2_neg ? negate(opdata2_i) : opdata2_i;

  // The quotient is negative when the operand signs differ. The remainder takes the dividend's sign.
  always_ff @(posedge Clk) begin
    if (load_ops) begin
      neg_q <= op1_neg ^ op2_neg;
      neg_r <= op1_neg;
    end
  end

  assign quo_fix = neg_q ? negate(work[DATA_W-1:0]) : work[DATA_W-1:0];
  assign rem_fix = neg_r ? negate(work[2*DATA_W-1:DATA_W]) : work[2*DATA_W-1:DATA_W];
`else
  logic unused_sign;

  assign unused_sign  = signed_div_i;
  assign dividend_mag = opdata1_i;
  assign divisor_mag  = opdata2_i;
  assign quo_fix      = work[DATA_W-1:0];
  assign rem_fix      = work[2*DATA_W-1:DATA_W];
`endif

  always_ff @(posedge Clk) begin
    if (load_ops) divisor <= divisor_mag;
  end

  // Each step shifts the remainder/dividend pair left by one bit. It then tries to subtract the divisor from the top half.
  assign shifted = work << 1;
  assign trial   = shifted[2*DATA_W:DATA_W] - {1'b0, divisor};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      work     <= work_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (opdata2_i == '0) ? BYZERO : ON;
      BYZERO:  state_nxt = END;
      ON: begin
        if (annul_i)             state_nxt = IDLE;
        else if (cnt == 6'd32)   state_nxt = END;
      end
      END:     if (!start_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt    = cnt;
    work_nxt   = work;
    result_nxt = result_o;
    ready_nxt  = ready_o;
    unique case (state)
      IDLE: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
        if (load_ops) begin
          cnt_nxt  = '0;
          work_nxt = {{(DATA_W+1){1'b0}}, dividend_mag};
        end
      end
      BYZERO: begin
        result_nxt = '0;
        ready_nxt  = 1'b1;
      end
      ON: begin
        if (annul_i) begin
          cnt_nxt    = '0;
          work_nxt   = '0;
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end else if (cnt != 6'd32) begin
          if (!trial[DATA_W]) work_nxt = {trial, shifted[DATA_W-1:1], 1'b1};
          else                work_nxt = shifted;
          cnt_nxt = cnt + 6'd1;
        end else begin
          result_nxt = {rem_fix, quo_fix};
          ready_nxt  = 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          result_nxt = '0;
          ready_nxt  = 1'b0;
        end
      end
      default: begin
        result_nxt = '0;
        ready_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed testbench for div_seq. It applies a table of division vectors and then runs the annul, reset and hold corner sequences.
module tb_div_seq;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_seq dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge from IDLE; start is sampled on the next edge (edge 0).
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int lat, input bit scramble);
    int hit;
    hit = -1;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (scramble && k == 3) begin
        opdata1_i    = ~a;
        opdata2_i    = '0;
        signed_div_i = ~sgn;
      end
      if (ready_o) begin
        hit = k;
        break;
      end
    end
    check({name, " latency"}, 64'(hit), 64'(lat));
    check({name, " result"}, result_o, exp);
    repeat (2) begin
      @(posedge Clk); #1;
      check({name, " hold ready"}, 64'(ready_o), 64'd1);
      check({name, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge Clk); #1;
    check({name, " release ready"}, 64'(ready_o), 64'd0);
    check({name, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    bit seen;
    int hit;

    vecs.push_back('{a: 32'd100,        b: 32'd7,          sgn: 1'b0, exp: 64'h00000002_0000000E, lat: 33});
    vecs.push_back('{a: 32'h12345678,   b: 32'd0,          sgn: 1'b0, exp: 64'h00000000_00000000, lat: 1});
    vecs.push_back('{a: 32'd9,          b: 32'd3,          sgn: 1'b0, exp: 64'h00000000_00000003, lat: 33});
    vecs.push_back('{a: 32'd5,          b: 32'd10,         sgn: 1'b0, exp: 64'h00000005_00000000, lat: 33});
    vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'd1,          sgn: 1'b0, exp: 64'h00000000_FFFFFFFF, lat: 33});
    vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   sgn: 1'b0, exp: 64'h00000000_00000001, lat: 33});
    vecs.push_back('{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b0, exp: 64'h80000000_00000000, lat: 33});
    vecs.push_back('{a: 32'd123456789,  b: 32'd10000,      sgn: 1'b0, exp: 64'h00001A85_00003039, lat: 33});
    vecs.push_back('{a: 32'hDEADBEEF,   b: 32'h10,         sgn: 1'b0, exp: 64'h0000000F_0DEADBEE, lat: 33});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{a: 32'hFFFFFFF9,   b: 32'd2,          sgn: 1'b1, exp: 64'hFFFFFFFF_FFFFFFFD, lat: 33});
    vecs.push_back('{a: 32'd7,          b: 32'hFFFFFFFE,   sgn: 1'b1, exp: 64'h00000001_FFFFFFFD, lat: 33});
    vecs.push_back('{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b1, exp: 64'h00000000_80000000, lat: 33});
    vecs.push_back('{a: 32'hFFFFFFFE,   b: 32'd2,          sgn: 1'b1, exp: 64'h00000000_FFFFFFFF, lat: 33});
`else
    vecs.push_back('{a: 32'hFFFFFFFE,   b: 32'd2,          sgn: 1'b1, exp: 64'h00000000_7FFFFFFF, lat: 33});
    vecs.push_back('{a: 32'hFFFFFFF9,   b: 32'd2,          sgn: 1'b1, exp: 64'h00000001_7FFFFFFC, lat: 33});
`endif

    // Reset: outputs stay clear even while start is held during reset.
    #3;
    check("reset ready", 64'(ready_o), 64'd0);
    check("reset result", result_o, 64'd0);
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("in reset ready", 64'(ready_o), 64'd0);
    Rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp, vecs[i].lat, 1'b0);

    run_div("scramble", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 1'b1);

    // Annul at edge 10 of a division.
    opdata1_i = 32'd1000;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (10) begin
      @(posedge Clk); #1;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge Clk); #1;
    annul_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (ready_o) seen = 1'b1;
    end
    check("annul no ready", 64'(seen), 64'd0);
    run_div("after annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 1'b0);

    // Start and annul together in IDLE.
    opdata1_i = 32'd9;
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (ready_o) seen = 1'b1;
    end
    check("start+annul idle", 64'(seen), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    @(posedge Clk); #1;

    // Asynchronous reset at cycle 20 of a division, then restart right away.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    repeat (20) begin
      @(posedge Clk); #1;
    end
    #2;
    Rst_n = 1'b0;
    #1;
    check("midop reset ready", 64'(ready_o), 64'd0);
    check("midop reset result", result_o, 64'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    run_div("after reset", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 1'b0);

    // Asynchronous reset while holding a finished result.
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i   = 1'b1;
    hit = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk); #1;
      if (ready_o) begin
        hit = k;
        break;
      end
    end
    check("end pre-reset latency", 64'(hit), 64'd33);
    check("end pre-reset result", result_o, 64'h00000002_0000000E);
    #2;
    Rst_n = 1'b0;
    #1;
    check("end reset ready", 64'(ready_o), 64'd0);
    check("end reset result", result_o, 64'd0);
    start_i = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    run_div("final", 32'd1000000, 32'd1000, 1'b0, 64'h00000000_000003E8, 33, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have ports Clk (in, 1, rising-edge clock) and Rst_n (in, 1, asynchronous active-low reset); one clock, Rst_n asserted = `RstEnable.
REQ-002 The block SHALL have signed_div_i (in, 1): 1 = signed operation, 0 = unsigned.
REQ-003 The block SHALL have opdata1_i (in, 32): dividend.
REQ-004 The block SHALL have opdata2_i (in, 32): divisor.
REQ-005 The block SHALL have start_i (in, 1): request from EX stage, held high until the result is consumed.
REQ-006 The block SHALL have annul_i (in, 1): cancel the in-flight operation (pipeline flush).
REQ-007 The block SHALL have result_o (out, 64, registered): {remainder[63:32], quotient[31:0]}.
REQ-008 The block SHALL have ready_o (out, 1, registered): result_o valid.

Function
REQ-009 The FSM SHALL have states IDLE, BYZERO, ON and END, with a 6-bit iteration counter cnt and a 65-bit working register.
REQ-010 In IDLE with start_i=1 and annul_i=0, the FSM SHALL go to BYZERO if opdata2_i==0, else latch operands, clear cnt and go to ON; otherwise it stays in IDLE with ready_o=0 and result_o=0.
REQ-011 BYZERO SHALL go to END on the next edge with quotient=0 and remainder=0.
REQ-012 In ON with annul_i=0 and cnt<32, each edge SHALL perform one restoring shift-subtract step, producing one quotient bit MSB-first, and increment cnt.
REQ-013 In ON at cnt==32, the next edge SHALL apply sign correction, load result_o, set ready_o=1 and go to END.
REQ-014 Latency SHALL be: start sampled at edge N gives ready_o high after edge N+33 (nonzero divisor) or after edge N+1 (zero divisor).
REQ-015 In END, result_o and ready_o SHALL hold while start_i=1; when start_i=0, the next edge SHALL return to IDLE with ready_o=0 and result_o=0.
REQ-016 annul_i=1 in ON SHALL return the FSM to IDLE on the next edge, discard partial state and leave ready_o=0.
REQ-017 Operands SHALL be sampled only on the IDLE->ON transition; input changes during ON SHALL NOT affect the result.
REQ-018 Signed mode SHALL divide magnitudes, negate the quotient when operand signs differ, and give the remainder the dividend's sign (truncating division).
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (two's-complement wrap, no trap).
REQ-020 start_i and annul_i both high in IDLE SHALL leave the FSM in IDLE.

Reset
REQ-021 Rst_n low SHALL asynchronously force state=IDLE, cnt=0, working register=0, result_o=`ZeroWord-extended 64'h0 and ready_o=0, including mid-operation.
REQ-022 After reset release, the first start_i SHALL be accepted on the first rising edge.

Configuration
REQ-023 With macro DIV_SIGNED_EN defined, signed_div_i SHALL select signed operation per REQ-018/REQ-019.
REQ-024 Without DIV_SIGNED_EN, signed_div_i SHALL be ignored, all operations SHALL be unsigned, and the sign-correction logic SHALL be omitted.

Verification
REQ-025 Unsigned 100/7 (start at edge 0): ready_o=1 after edge 33 with result_o=64'h00000002_0000000E; drop start_i, so ready_o=0 and result_o=0 after the next edge.
REQ-026 Divisor 0 with dividend 0x12345678: ready_o=1 after edge 1 with result_o=0.
REQ-027 Signed (DIV_SIGNED_EN) -7/2: quotient 0xFFFFFFFD and remainder 0xFFFFFFFF; 7/-2 gives quotient 0xFFFFFFFD and remainder 0x00000001; 0x80000000/0xFFFFFFFF per REQ-019.
REQ-028 annul_i pulsed at edge 10 of a division: IDLE after edge 11 and ready_o never asserts; a new 9/3 then completes with result_o=64'h00000000_00000003.
REQ-029 Rst_n dropped asynchronously at cycle 20 of a division: ready_o=0 and result_o=0 immediately, with no clock edge required.
REQ-030 Without DIV_SIGNED_EN, signed_div_i=1 with 0xFFFFFFFE/2 SHALL give quotient 0x7FFFFFFF and remainder 0.
